sti_load_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the serial transmitter (STI).
- Accepts parallel-word commands from two sources over valid/ready handshakes.
- Issues each accepted command to STI as a one-cycle load with the pi_* fields, then tracks serialization by counting so_valid cycles.
- Emits pi_end once both sources have delivered their last word and the final word has fully shifted out.

---
 rtl/sti_load_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sti_load_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sti_load_arbiter.sv
// sti_load_arbiter
// Two-requester arbiter and sequencer in front of the serial transmitter (STI).
// Commands from requesters A and B are accepted over valid/ready handshakes,
// issued to STI as a one-cycle load with the captured pi_* fields, and the
// serialization is tracked by counting so_valid cycles. When both requesters
// have delivered their last word and it has shifted out, pi_end pulses once
// and the block parks in FINISH until reset.
//
// Build option: define STI_ARB_FIXED_PRIO_EN to make A win every tie (fixed
// priority, no round-robin pointer). Undefined: ties alternate round-robin.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   a_* / b_*                  requester command channels (valid/ready, data,
//                              length code, fill/msb/low mode bits, last)
//   load                       one-cycle load strobe to STI
//   pi_data/length/fill/msb/low captured command fields to STI
//   pi_end                     one-cycle end-of-stream pulse
//   so_valid                   STI serial-valid feedback
//   grant                      one-hot owner of current transfer {B,A}
//   busy                       high outside IDLE and FINISH
//   err_timeout, err_short     sticky error flags
//   xfer_cnt                   completed full-length transfers (wraps)
module sti_load_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TCNT_W  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [15:0] a_data,
  input  logic [1:0]  a_length,
  input  logic        a_fill,
  input  logic        a_msb,
  input  logic        a_low,
  input  logic        a_last,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [15:0] b_data,
  input  logic [1:0]  b_length,
  input  logic        b_fill,
  input  logic        b_msb,
  input  logic        b_low,
  input  logic        b_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_short,
  output logic [7:0]  xfer_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_END    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [TCNT_W-1:0] TMO = TCNT_W'(TIMEOUT);

  logic [2:0]        state;
  logic              a_done, b_done;
  logic [TCNT_W-1:0] tcnt;
  logic [TCNT_W-1:0] tcnt_nxt;
  logic [5:0]        bcnt;
  logic [5:0]        bcnt_nxt;
  logic [5:0]        exp_bits;
  logic              a_el, b_el;
  logic              sel_a, sel_b;

  assign a_el = a_valid & ~a_done;
  assign b_el = b_valid & ~b_done;

`ifdef STI_ARB_FIXED_PRIO_EN
  assign sel_a = a_el;
`else
  // last_b=1 means B was granted most recently; resets to 1 so A wins the first tie.
  logic last_b;
  assign sel_a = a_el & (~b_el | last_b);
`endif
  assign sel_b = b_el & ~sel_a;

  always_comb begin
    a_ready = (state == S_IDLE) & sel_a;
    b_ready = (state == S_IDLE) & sel_b;
    load    = (state == S_LOAD);
    pi_end  = (state == S_END);
    busy    = (state != S_IDLE) & (state != S_FINISH);
  end

  // Expected bit count 8*(length+1); length 3 gives 32, which fits in 6 bits.
  assign exp_bits = {1'b0, pi_length, 3'b000} + 6'd8;
  assign bcnt_nxt = bcnt + 6'd1;
  assign tcnt_nxt = tcnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      a_done      <= 1'b0;
      b_done      <= 1'b0;
      tcnt        <= '0;
      bcnt        <= '0;
      pi_data     <= '0;
      pi_length   <= '0;
      pi_fill     <= 1'b0;
      pi_msb      <= 1'b0;
      pi_low      <= 1'b0;
      grant       <= '0;
      err_timeout <= 1'b0;
      err_short   <= 1'b0;
      xfer_cnt    <= '0;
`ifndef STI_ARB_FIXED_PRIO_EN
      last_b      <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (a_ready | b_ready) begin
            pi_data   <= a_ready ? a_data   : b_data;
            pi_length <= a_ready ? a_length : b_length;
            pi_fill   <= a_ready ? a_fill   : b_fill;
            pi_msb    <= a_ready ? a_msb    : b_msb;
            pi_low    <= a_ready ? a_low    : b_low;
            grant     <= {b_ready, a_ready};
`ifndef STI_ARB_FIXED_PRIO_EN
            last_b    <= b_ready;
`endif
            // done is latched at the handshake, so aborted last commands still count
            if (a_ready & a_last) a_done <= 1'b1;
            if (b_ready & b_last) b_done <= 1'b1;
            state <= S_LOAD;
          end else if (a_done & b_done) begin
            state <= S_END;
          end
        end
        S_LOAD: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (so_valid) begin
            bcnt  <= 6'd1;
            state <= S_SHIFT;
          end else if (tcnt_nxt == TMO) begin
            err_timeout <= 1'b1;
            grant       <= '0;
            state       <= S_GAP;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        S_SHIFT: begin
          if (so_valid) begin
            bcnt <= bcnt_nxt;
            if (bcnt_nxt == exp_bits) begin
              xfer_cnt <= xfer_cnt + 8'd1;
              grant    <= '0;
              state    <= S_GAP;
            end
          end else begin
            err_short <= 1'b1;
            grant     <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP:    state <= (a_done & b_done) ? S_END : S_IDLE;
        S_END:    state <= S_FINISH;
        S_FINISH: state <= S_FINISH;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_load_arbiter.sv
// Directed, table-driven bench for sti_load_arbiter (default round-robin build).
module tb_sti_load_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, a_ready, a_fill, a_msb, a_low, a_last;
  logic [15:0] a_data;
  logic [1:0]  a_length;
  logic        b_valid, b_ready, b_fill, b_msb, b_low, b_last;
  logic [15:0] b_data;
  logic [1:0]  b_length;
  logic        load, pi_fill, pi_msb, pi_low, pi_end, so_valid, busy;
  logic [15:0] pi_data;
  logic [1:0]  pi_length, grant;
  logic        err_timeout, err_short;
  logic [7:0]  xfer_cnt;

  int checks   = 0;
  int failures = 0;

  sti_load_arbiter #(.TIMEOUT(15), .TCNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_length(a_length),
    .a_fill(a_fill), .a_msb(a_msb), .a_low(a_low), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_length(b_length),
    .b_fill(b_fill), .b_msb(b_msb), .b_low(b_low), .b_last(b_last),
    .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end), .so_valid(so_valid),
    .grant(grant), .busy(busy), .err_timeout(err_timeout), .err_short(err_short),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        av;
    logic [15:0] ad;
    logic [1:0]  al;
    logic [2:0]  am;
    logic        alast;
    logic        bv;
    logic [15:0] bd;
    logic [1:0]  bl;
    logic [2:0]  bm;
    logic        blast;
    int          nbits;  // so_valid cycles supplied after the load (0 = none)
    logic [1:0]  g;      // expected grant / ready pair {B,A}
    logic [15:0] d;
    logic [1:0]  l;
    logic [2:0]  m;      // {fill,msb,low}
    logic        to;
    logic        sh;
    logic [7:0]  x;
    int          gap;    // negedges after the load cycle until grant clears
    logic        fin;    // GAP followed by END/FINISH
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [15:0] ad, input logic [1:0] al, input logic [2:0] am, input logic alast,
    input logic bv, input logic [15:0] bd, input logic [1:0] bl, input logic [2:0] bm, input logic blast,
    input int nbits, input logic [1:0] g, input logic to, input logic sh, input logic [7:0] x,
    input int gap, input logic fin);
    vec_t v;
    v.av = av; v.ad = ad; v.al = al; v.am = am; v.alast = alast;
    v.bv = bv; v.bd = bd; v.bl = bl; v.bm = bm; v.blast = blast;
    v.nbits = nbits; v.g = g; v.to = to; v.sh = sh; v.x = x; v.gap = gap; v.fin = fin;
    v.d = (g == 2'b01) ? ad : bd;
    v.l = (g == 2'b01) ? al : bl;
    v.m = (g == 2'b01) ? am : bm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_data = '0; a_length = '0; a_fill = 0; a_msb = 0; a_low = 0; a_last = 0;
    b_valid = 0; b_data = '0; b_length = '0; b_fill = 0; b_msb = 0; b_low = 0; b_last = 0;
    so_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_load", 32'(load), 0);
    chk("rst_pi_end", 32'(pi_end), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_pi_data", 32'(pi_data), 0);
    chk("rst_pi_len_mode", 32'({pi_length, pi_fill, pi_msb, pi_low}), 0);
    chk("rst_errs", 32'({err_timeout, err_short}), 0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 0);
    chk("rst_readies", 32'({b_ready, a_ready}), 0);
    reset = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    int cyc;
    @(negedge clk);
    a_valid = v.av; a_data = v.ad; a_length = v.al; {a_fill, a_msb, a_low} = v.am; a_last = v.alast;
    b_valid = v.bv; b_data = v.bd; b_length = v.bl; {b_fill, b_msb, b_low} = v.bm; b_last = v.blast;
    #1;
    chk("ready", 32'({b_ready, a_ready}), 32'(v.g));
    @(posedge clk);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    chk("load", 32'(load), 1);
    chk("grant", 32'(grant), 32'(v.g));
    chk("pi_data", 32'(pi_data), 32'(v.d));
    chk("pi_length", 32'(pi_length), 32'(v.l));
    chk("pi_mode", 32'({pi_fill, pi_msb, pi_low}), 32'(v.m));
    @(negedge clk);
    cyc = 1;
    chk("load_width", 32'(load), 0);
    so_valid = (v.nbits > 0);
    for (int k = 1; k < v.nbits; k++) begin
      @(negedge clk);
      cyc++;
      so_valid = 1;
    end
    @(negedge clk);
    cyc++;
    so_valid = 0;
    while (grant != 2'b00 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("gap_cycle", 32'(cyc), 32'(v.gap));
    chk("gap_busy", 32'(busy), 1);
    chk("err_timeout", 32'(err_timeout), 32'(v.to));
    chk("err_short", 32'(err_short), 32'(v.sh));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(v.x));
    @(negedge clk);
    chk("pi_end", 32'(pi_end), 32'(v.fin));
    chk("post_gap_busy", 32'(busy), 32'(v.fin));
    chk("pi_data_hold", 32'(pi_data), 32'(v.d));
    if (v.fin) begin
      @(negedge clk);
      chk("pi_end_width", 32'(pi_end), 0);
      chk("finish_busy", 32'(busy), 0);
    end
  endtask

  vec_t tab1[5];
  vec_t tab2[8];

  initial begin
    // Segment 1: single A command, then B-only traffic incl. timeout and short abort.
    tab1[0] = mk(1, 16'hA5C3, 2'b01, 3'b101, 1, 0, 16'h0000, 2'b00, 3'b000, 0, 16, 2'b01, 0, 0, 8'd1, 17, 0);
    tab1[1] = mk(1, 16'hFFFF, 2'b00, 3'b000, 0, 1, 16'h1111, 2'b00, 3'b010, 0,  8, 2'b10, 0, 0, 8'd2,  9, 0);
    tab1[2] = mk(0, 16'h0000, 2'b00, 3'b000, 0, 1, 16'h2222, 2'b00, 3'b001, 0,  0, 2'b10, 1, 0, 8'd2, 16, 0);
    tab1[3] = mk(0, 16'h0000, 2'b00, 3'b000, 0, 1, 16'h3333, 2'b11, 3'b111, 0, 20, 2'b10, 1, 1, 8'd2, 22, 0);
    tab1[4] = mk(1, 16'hEEEE, 2'b01, 3'b000, 0, 1, 16'h4444, 2'b10, 3'b000, 1, 24, 2'b10, 1, 1, 8'd3, 25, 1);
    // Segment 2: both requesters valid every command, round-robin alternation.
    for (int i = 0; i < 8; i++)
      tab2[i] = mk(1, 16'hA000 + 16'(i), 2'b00, 3'b100, (i == 6),
                   1, 16'hB000 + 16'(i), 2'b00, 3'b011, (i == 7),
                   8, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0, 8'(i + 1), 9, (i == 7));

    do_reset();
    for (int i = 0; i < 5; i++) apply(tab1[i]);

    do_reset();
    for (int i = 0; i < 8; i++) apply(tab2[i]);

    // FINISH is terminal: requests are ignored and no strobes appear.
    a_valid = 1; b_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("finish_readies", 32'({b_ready, a_ready}), 0);
      chk("finish_strobes", 32'({load, pi_end, busy}), 0);
    end

    // Reset asserted mid-SHIFT of a 32-bit transfer.
    do_reset();
    @(negedge clk);
    a_valid = 1; a_data = 16'h5A5A; a_length = 2'b11; {a_fill, a_msb, a_low} = 3'b110; a_last = 0;
    b_valid = 1; b_data = 16'h6B6B; b_length = 2'b00; {b_fill, b_msb, b_low} = 3'b001; b_last = 0;
    #1;
    chk("first_tie_a", 32'({b_ready, a_ready}), 2'b01);
    @(posedge clk);
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      so_valid = 1;
    end
    chk("shift_busy", 32'(busy), 1);
    chk("shift_grant", 32'(grant), 2'b01);
    #2;
    reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_grant", 32'(grant), 0);
    chk("async_load", 32'(load), 0);
    chk("async_pi_data", 32'(pi_data), 0);
    @(negedge clk);
    so_valid = 0;
    reset = 1'b1;
    // A was granted last before reset; the pointer reset must still favour A.
    apply(mk(1, 16'h1234, 2'b00, 3'b010, 0, 1, 16'h5678, 2'b00, 3'b100, 0,
             8, 2'b01, 0, 0, 8'd1, 9, 0));

    // xfer_cnt wraps after 256 completed transfers.
    do_reset();
    for (int i = 0; i < 256; i++)
      apply(mk(1, 16'(i), 2'b00, 3'b000, 0, 0, 16'h0000, 2'b00, 3'b000, 0,
               8, 2'b01, 0, 0, 8'(i + 1), 9, 0));
    chk("xfer_wrap", 32'(xfer_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
